sd_cmd_engine: RTL and testbench
================================

// Module: sd_cmd_engine
// PURPOSE
//  CPU-mapped SD command-line engine, the parametrised successor to the basic command controller.
//  - Generates sd_clk from the system clock.
//  - Serialises a 48-bit command frame with a serially computed CRC7.
//  - Optionally waits for and captures a 48-bit response, with timeout and response-CRC checking.
//  - Sits on the 6502 bus beside the SD data-path logic.
// PARAMETERS
//  CLK_DIV       4   clk cycles per sd_clk period; even, >=2
//  RESP_TIMEOUT  64  sd_clk periods to wait for a response start bit (NCR limit)
// PORTS
//  clk         in   1  system clock; single clock domain
//  rst         in   1  reset, asynchronous, active-high
//  addr        in   4  register address
//  data        in   8  CPU write data
//  data_out    out  8  CPU read data; combinational from addr
//  cs          in   1  chip select; one access per cycle asserted
//  rw          in   1  1=read, 0=write
//  o_sd_clk    out  1  SD clock
//  i_sd_cmd    in   1  CMD line input (pulled-up)
//  o_sd_cmd    out  1  CMD line drive value
//  o_sd_cmd_oe out  1  CMD line output enable
//  o_irq       out  1  level, = STATUS.done
// BEHAVIOUR
//  Register map:
//  - 0-3 ARG bytes, LSB first (W). Writes are ignored while busy.
//  - 4 CMD (W): [5:0] index, [6] expect response, [7] skip response CRC check. Write starts a command; ignored while busy.
//  - 5 STATUS (R): [0] busy, [1] done, [2] timeout, [3] crc_err. A read with cs clears [3:1] at the end of that cycle.
//  - 8-13 RESP bytes (R), RESP[7:0] first, holding the raw 48-bit frame including start/CRC/end bits.
//  - Unmapped reads return 0x00.
//  Clock generation:
//  - div_cnt counts 0..CLK_DIV-1 continuously and wraps.
//  - o_sd_clk = (div_cnt >= CLK_DIV/2).
//  - shift strobe: div_cnt==0. CMD changes only on shift.
//  - sample strobe: div_cnt==CLK_DIV/2. i_sd_cmd is read only on sample.
//  State machine IDLE -> TX -> (WAIT -> RX) -> IDLE:
//  - IDLE: oe=0, o_sd_cmd=1. A CMD write latches the frame {0,1,idx,ARG}, clears done/timeout/crc_err, sets busy, and enters TX.
//  - TX: oe=1.
//    - On each shift, drive the next bit MSB first.
//    - Bits 47..8 feed the CRC7 (x^7+x^3+1, seed 0).
//    - Bits 7..1 are the CRC, MSB first; bit 0 is the end bit (1).
//    - On the shift after the end bit: oe=0. If CMD[6] go to WAIT, else set done, clear busy, go to IDLE.
//  - WAIT: count sample strobes.
//    - i_sd_cmd==0 on a sample: store 0 as RESP[47], enter RX.
//    - RESP_TIMEOUT samples with no start bit: set timeout and done, clear busy, go to IDLE. RESP is left unchanged.
//  - RX: shift in the 47 further bits on samples into RESP[46:0], MSB first.
//    - After RESP[0]: set done, clear busy, go to IDLE.
//    - crc_err per CONFIGURATION.
//  - The same 7-bit CRC engine is reused for TX and RX. The bit counter is 6 bits and never wraps past 47.
//  - A STATUS read coinciding with a done set: the set wins.
//  - The CMD write that starts a command clears the flags in the same cycle.
//  - rst at any time: state=IDLE, div_cnt=0, o_sd_clk=0, oe=0, o_sd_cmd=1, STATUS=0, ARG/CMD/RESP=0, o_irq=0. No partial frame resumes.
// CONFIGURATION
//  SD_RESP_CRC_CHECK_EN
//  - Defined: at end of RX, if CMD[7]==0 and the CRC7 over RESP[47:8] != RESP[7:1], or RESP[0]!=1, set crc_err. done is still set.
//  - Undefined: crc_err is tied 0. No RX CRC logic is instantiated; the TX CRC is unchanged.
// TESTING
//  (CLK_DIV=4 unless noted; the bench models the card on o_sd_clk edges)
//  1. Write ARG=0, CMD=0x00 -> CMD line shows 0x40_00000000_95 over 48 sd_clks. Then busy=0, done=1, o_irq=1, oe=0. STATUS read -> 0x02, next read 0x00.
//  2. ARG=0x000001AA, CMD=0x48; card answers 2 clks later with 08_000001AA_13 -> TX CRC byte 0x87. RESP bytes 8..13 = 13,AA,01,00,00,08. STATUS=0x02.
//  3. CMD=0x48 with the card silent -> timeout after 64 sample strobes. STATUS=0x06, RESP unchanged.
//  4. Macro defined: card response with CRC byte 0x15 -> STATUS=0x0A. Same with CMD=0xC8 -> 0x02. Macro undefined -> 0x02.
//  5. Writes of CMD=0x51 and ARG0 mid-TX -> ignored; the frame on the line is unchanged and exactly one command is sent.
//  6. rst asserted at bit 20 of TX -> all outputs at reset values immediately (async). A new CMD then sends a clean, full 48-bit frame.

Source files
------------

// File: rtl/sd_cmd_engine_if.sv
// sd_cmd_engine_if
//   CPU (6502-side) register bus for the SD command engine.
//   addr      register address
//   data      CPU write data
//   data_out  CPU read data (combinational from addr)
//   cs        chip select, one access per asserted cycle
//   rw        1 = read, 0 = write
//   o_irq     level interrupt, mirrors STATUS.done
//   master modport: CPU / bench side; slave modport: the engine.
interface sd_cmd_engine_if;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] data_out;
    logic       cs;
    logic       rw;
    logic       o_irq;

    modport master (output addr, data, cs, rw, input data_out, o_irq);
    modport slave  (input addr, data, cs, rw, output data_out, o_irq);
endinterface

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine
//   CPU-mapped SD command-line engine. Divides clk into o_sd_clk, shifts out a
//   48-bit command frame with a serially built CRC7, and optionally captures a
//   48-bit response with timeout detection.
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   bus           sd_cmd_engine_if.slave register bus (addr/data/data_out/cs/rw/o_irq)
//   o_sd_clk      SD clock, high for the second half of each divider period
//   i_sd_cmd      CMD line input (pulled-up)
//   o_sd_cmd      CMD line drive value
//   o_sd_cmd_oe   CMD line output enable
// Register map
//   0-3 ARG (W, LSB first), 4 CMD (W: [5:0] idx, [6] expect resp, [7] skip resp CRC),
//   5 STATUS (R: [0] busy [1] done [2] timeout [3] crc_err, read clears [3:1]),
//   8-13 RESP (R, RESP[7:0] first). Others read 0.
// Build option
//   SD_RESP_CRC_CHECK_EN  when defined, the response CRC7/end bit is checked
//                         and reported in STATUS.crc_err; otherwise crc_err is 0.
module sd_cmd_engine #(
    parameter int CLK_DIV      = 4,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    sd_cmd_engine_if.slave        bus,
    output logic                  o_sd_clk,
    input  logic                  i_sd_cmd,
    output logic                  o_sd_cmd,
    output logic                  o_sd_cmd_oe
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(RESP_TIMEOUT) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TX   = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RX   = 2'd3;

    logic [DW-1:0] div_cnt;
    logic          shift, sample;
    logic [1:0]    state;
    logic [31:0]   arg;
    logic          resp_en;
    logic [47:0]   resp;
    logic [39:0]   tx_sr;     // {0,1,idx,ARG}, shifted out MSB first
    logic [5:0]    bit_cnt;   // frame bit index, counts down, never wraps
    logic          tx_last;   // end bit is on the line; next shift releases
    logic [6:0]    crc;
    logic [TW-1:0] tmo_cnt;
    logic          done, timeout, crc_err;
    logic          busy;
    logic          cmd_wr, arg_wr, stat_rd;
    logic          fin, fin_tmo, fin_crc;
`ifdef SD_RESP_CRC_CHECK_EN
    logic          skip_crc;
`endif

    // Serial CRC7, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    assign busy     = (state != S_IDLE);
    assign shift    = (div_cnt == '0);
    assign sample   = (div_cnt == DIV_HALF);
    assign o_sd_clk = (div_cnt >= DIV_HALF);
    assign bus.o_irq = done;

    assign cmd_wr  = bus.cs && !bus.rw && (bus.addr == 4'd4) && !busy;
    assign arg_wr  = bus.cs && !bus.rw && (bus.addr < 4'd4) && !busy;
    assign stat_rd = bus.cs &&  bus.rw && (bus.addr == 4'd5);

    // Clock divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                        div_cnt <= div_cnt + DW'(1);
    end

    // Completion events for the status flags
    always_comb begin
        fin     = 1'b0;
        fin_tmo = 1'b0;
        fin_crc = 1'b0;
        case (state)
            S_TX:   if (shift && tx_last && !resp_en) fin = 1'b1;
            S_WAIT: if (sample && i_sd_cmd && tmo_cnt == TMO_LAST) begin
                        fin     = 1'b1;
                        fin_tmo = 1'b1;
                    end
            S_RX:   if (sample && bit_cnt == 6'd0) begin
                        fin = 1'b1;
`ifdef SD_RESP_CRC_CHECK_EN
                        // resp[7:1] is already stored; the end bit is on the line now
                        fin_crc = !skip_crc && ((crc != resp[7:1]) || !i_sd_cmd);
`endif
                    end
            default: ;
        endcase
    end

    // Status flags: a start clears them; a completion beats a same-cycle read-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            crc_err <= 1'b0;
        end else if (cmd_wr) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            crc_err <= 1'b0;
        end else begin
            if (stat_rd) begin
                done    <= 1'b0;
                timeout <= 1'b0;
                crc_err <= 1'b0;
            end
            if (fin)     done    <= 1'b1;
            if (fin_tmo) timeout <= 1'b1;
            if (fin_crc) crc_err <= 1'b1;
        end
    end

    // ARG register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) arg <= '0;
        else if (arg_wr) arg[8*bus.addr[1:0] +: 8] <= bus.data;
    end

    // Command / response sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            resp_en     <= 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
            skip_crc    <= 1'b0;
`endif
            resp        <= '0;
            tx_sr       <= '0;
            bit_cnt     <= '0;
            tx_last     <= 1'b0;
            crc         <= '0;
            tmo_cnt     <= '0;
            o_sd_cmd    <= 1'b1;
            o_sd_cmd_oe <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_wr) begin
                        resp_en  <= bus.data[6];
`ifdef SD_RESP_CRC_CHECK_EN
                        skip_crc <= bus.data[7];
`endif
                        tx_sr    <= {2'b01, bus.data[5:0], arg};
                        bit_cnt  <= 6'd47;
                        tx_last  <= 1'b0;
                        crc      <= '0;
                        state    <= S_TX;
                    end
                end
                S_TX: begin
                    if (shift) begin
                        if (tx_last) begin
                            o_sd_cmd_oe <= 1'b0;
                            o_sd_cmd    <= 1'b1;
                            crc         <= '0;
                            tmo_cnt     <= '0;
                            state       <= resp_en ? S_WAIT : S_IDLE;
                        end else begin
                            o_sd_cmd_oe <= 1'b1;
                            if (bit_cnt >= 6'd8) begin
                                o_sd_cmd <= tx_sr[39];
                                tx_sr    <= {tx_sr[38:0], 1'b0};
                                crc      <= crc7_step(crc, tx_sr[39]);
                            end else if (bit_cnt != 6'd0) begin
                                o_sd_cmd <= crc[6];
                                crc      <= {crc[5:0], 1'b0};
                            end else begin
                                o_sd_cmd <= 1'b1;
                            end
                            if (bit_cnt == 6'd0) tx_last <= 1'b1;
                            else                 bit_cnt <= bit_cnt - 6'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (sample) begin
                        if (!i_sd_cmd) begin
                            resp[47] <= 1'b0;
                            bit_cnt  <= 6'd46;
`ifdef SD_RESP_CRC_CHECK_EN
                            crc      <= crc7_step(crc, 1'b0);
`endif
                            state    <= S_RX;
                        end else if (tmo_cnt == TMO_LAST) begin
                            state    <= S_IDLE;
                        end else begin
                            tmo_cnt  <= tmo_cnt + TW'(1);
                        end
                    end
                end
                S_RX: begin
                    if (sample) begin
                        resp[bit_cnt] <= i_sd_cmd;
`ifdef SD_RESP_CRC_CHECK_EN
                        if (bit_cnt >= 6'd8) crc <= crc7_step(crc, i_sd_cmd);
`endif
                        if (bit_cnt == 6'd0) state   <= S_IDLE;
                        else                 bit_cnt <= bit_cnt - 6'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read mux
    always_comb begin
        bus.data_out = 8'h00;
        case (bus.addr)
            4'd5:  bus.data_out = {4'b0000, crc_err, timeout, done, busy};
            4'd8:  bus.data_out = resp[7:0];
            4'd9:  bus.data_out = resp[15:8];
            4'd10: bus.data_out = resp[23:16];
            4'd11: bus.data_out = resp[31:24];
            4'd12: bus.data_out = resp[39:32];
            4'd13: bus.data_out = resp[47:40];
            default: bus.data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
module tb_sd_cmd_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sd_clk, sd_cmd, sd_oe;
    logic card_cmd = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [47:0] cap = '0;
    int   cap_n = 0;
    int   n0;
    logic [7:0] rv;

    sd_cmd_engine_if bus();

    sd_cmd_engine #(.CLK_DIV(4), .RESP_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_sd_clk(sd_clk), .i_sd_cmd(card_cmd),
        .o_sd_cmd(sd_cmd), .o_sd_cmd_oe(sd_oe)
    );

    always #5 clk = ~clk;

    // card side: latch host bits on the rising sd_clk edge
    always @(posedge sd_clk) begin
        if (sd_oe) begin
            cap   <= {cap[46:0], sd_cmd};
            cap_n <= cap_n + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = a; bus.data = d;
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.rw = 1'b1; bus.addr = a;
        #1 d = bus.data_out;
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (bus.o_irq) begin ok = 1'b1; break; end
        end
        chk(tag, {47'b0, ok}, 48'd1);
    endtask

    task automatic wait_oe_fall(input string tag);
        logic seen, ok;
        seen = 1'b0; ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (sd_oe) seen = 1'b1;
            if (seen && !sd_oe) begin ok = 1'b1; break; end
        end
        chk(tag, {47'b0, ok}, 48'd1);
    endtask

    // card response: start bit goes out on the dly-th falling sd_clk after release
    task automatic drive_resp(input logic [47:0] r, input int dly);
        wait_oe_fall("resp_oe_fall");
        repeat (dly) @(negedge sd_clk);
        for (int i = 47; i >= 0; i--) begin
            card_cmd = r[i];
            @(negedge sd_clk);
        end
        card_cmd = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] v;
        rd(a, v);
        chk(tag, {40'b0, v}, {40'b0, exp});
    endtask

    initial begin
        bus.cs = 1'b0; bus.rw = 1'b1; bus.addr = 4'd0; bus.data = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_oe",    {47'b0, sd_oe},    48'd0);
        chk("rst_cmd",   {47'b0, sd_cmd},   48'd1);
        chk("rst_sdclk", {47'b0, sd_clk},   48'd0);
        chk("rst_irq",   {47'b0, bus.o_irq}, 48'd0);
        rst = 1'b0;
        rd_chk("rst_status", 4'd5, 8'h00);
        rd_chk("rst_resp8",  4'd8, 8'h00);
        rd_chk("unmapped",   4'd15, 8'h00);

        // 1: CMD0, no response
        wr(4'd0, 8'h00); wr(4'd1, 8'h00); wr(4'd2, 8'h00); wr(4'd3, 8'h00);
        n0 = cap_n;
        wr(4'd4, 8'h00);
        rd_chk("t1_busy", 4'd5, 8'h01);
        wait_done("t1_done");
        chk("t1_frame", cap, 48'h40_00000000_95);
        chk("t1_nbits", 48'(cap_n - n0), 48'd48);
        chk("t1_oe", {47'b0, sd_oe}, 48'd0);
        chk("t1_irq", {47'b0, bus.o_irq}, 48'd1);
        rd_chk("t1_status", 4'd5, 8'h02);
        rd_chk("t1_status_clr", 4'd5, 8'h00);
        chk("t1_irq_clr", {47'b0, bus.o_irq}, 48'd0);

        // 2: CMD8 with R7 response
        wr(4'd0, 8'hAA); wr(4'd1, 8'h01); wr(4'd2, 8'h00); wr(4'd3, 8'h00);
        wr(4'd4, 8'h48);
        drive_resp(48'h08_000001AA_13, 2);
        wait_done("t2_done");
        chk("t2_frame", cap, 48'h48_000001AA_87);
        rd_chk("t2_status", 4'd5, 8'h02);
        rd_chk("t2_resp8",  4'd8,  8'h13);
        rd_chk("t2_resp9",  4'd9,  8'hAA);
        rd_chk("t2_resp10", 4'd10, 8'h01);
        rd_chk("t2_resp11", 4'd11, 8'h00);
        rd_chk("t2_resp12", 4'd12, 8'h00);
        rd_chk("t2_resp13", 4'd13, 8'h08);

        // 3: silent card -> timeout on the 64th sample (254 clks after release)
        wr(4'd4, 8'h48);
        wait_oe_fall("t3_oe_fall");
        repeat (248) @(posedge clk);
        #1 chk("t3_not_yet", {47'b0, bus.o_irq}, 48'd0);
        repeat (10) @(posedge clk);
        #1 chk("t3_timeout", {47'b0, bus.o_irq}, 48'd1);
        rd_chk("t3_status", 4'd5, 8'h06);
        rd_chk("t3_resp8",  4'd8,  8'h13);
        rd_chk("t3_resp13", 4'd13, 8'h08);

        // 4: bad response CRC
        wr(4'd4, 8'h48);
        drive_resp(48'h08_000001AA_15, 2);
        wait_done("t4_done");
`ifdef SD_RESP_CRC_CHECK_EN
        rd_chk("t4_status", 4'd5, 8'h0A);
`else
        rd_chk("t4_status", 4'd5, 8'h02);
`endif
        rd_chk("t4_resp8", 4'd8, 8'h15);
        wr(4'd4, 8'hC8);
        drive_resp(48'h08_000001AA_15, 2);
        wait_done("t4_skip_done");
        rd_chk("t4_skip_status", 4'd5, 8'h02);

        // 5: writes while busy are ignored
        wr(4'd0, 8'h00); wr(4'd1, 8'h00);
        n0 = cap_n;
        wr(4'd4, 8'h00);
        repeat (60) @(negedge clk);
        wr(4'd4, 8'h51);
        wr(4'd0, 8'hFF);
        wait_done("t5_done");
        chk("t5_frame", cap, 48'h40_00000000_95);
        chk("t5_nbits", 48'(cap_n - n0), 48'd48);
        repeat (20) @(negedge clk);
        chk("t5_one_cmd", 48'(cap_n - n0), 48'd48);
        n0 = cap_n;
        wr(4'd4, 8'h00);
        wait_done("t5b_done");
        chk("t5b_arg_kept", cap, 48'h40_00000000_95);

        // 6: async reset mid-TX, then a clean frame
        rd(4'd5, rv);
        n0 = cap_n;
        wr(4'd4, 8'h00);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (cap_n - n0 >= 20) break;
        end
        chk("t6_reached20", 48'(cap_n - n0), 48'd20);
        #2 rst = 1'b1;
        bus.addr = 4'd5;
        #1;
        chk("t6_oe",     {47'b0, sd_oe},  48'd0);
        chk("t6_cmd",    {47'b0, sd_cmd}, 48'd1);
        chk("t6_sdclk",  {47'b0, sd_clk}, 48'd0);
        chk("t6_irq",    {47'b0, bus.o_irq}, 48'd0);
        chk("t6_status", {40'b0, bus.data_out}, 48'd0);
        @(negedge clk);
        rst = 1'b0;
        n0 = cap_n;
        wr(4'd4, 8'h00);
        wait_done("t6_done");
        chk("t6_frame", cap, 48'h40_00000000_95);
        chk("t6_nbits", 48'(cap_n - n0), 48'd48);
        rd_chk("t6_status_after", 4'd5, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
